// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants for the tick generator timebase.
//   RW_DEF, NCH_DEF, RATIOS_DEF : default ratio field width, channel count and
//                                 ratio vector (ch0=1, ch1=10, ch2=100)
//   CLK_HZ_DEF, BASE_HZ_DEF     : default board clock and prescaler tick rate
//   ratio_prod()                : product of ratios for channels 0..last, so
//                                 tick[last] period = PRE * ratio_prod(...)
package tick_gen_pkg;

    localparam int unsigned RW_DEF        = 16;
    localparam int unsigned NCH_DEF       = 3;
    localparam logic [NCH_DEF*RW_DEF-1:0] RATIOS_DEF = {16'd100, 16'd10, 16'd1};
    localparam int unsigned CLK_HZ_DEF    = 24_000_000;
    localparam int unsigned BASE_HZ_DEF   = 1000;
    localparam int unsigned RATIO_VEC_MAX = 1024;

    function automatic longint unsigned ratio_prod(
        input logic [RATIO_VEC_MAX-1:0] ratios,
        input int unsigned              rw,
        input int unsigned              last
    );
        longint unsigned          p;
        longint unsigned          mask;
        logic [RATIO_VEC_MAX-1:0] sh;
        p    = 64'd1;
        mask = (rw >= 64) ? '1 : ((64'd1 << rw) - 64'd1);
        for (int unsigned i = 0; i <= last; i++) begin
            sh = ratios >> (i * rw);
            p  = p * (sh[63:0] & mask);
        end
        return p;
    endfunction

endpackage

// File: rtl/tick_div_stage.sv
// tick_div_stage: one cascaded divider channel of tick_gen.
//   clk, rst (sync, active-high), clr (sync restart)
//   up_wrap : wrap strobe of the upstream stage (or prescaler)
//   wrap    : combinational wrap of this stage (upstream wrap && last count)
//   cp      : toggle clock, flips on every wrap; only built when the macro
//             TICK_GEN_CP_EN is defined, otherwise tied to 0.
// Parameter RATIO: number of upstream wraps per wrap of this stage (>= 1).
module tick_div_stage
    import tick_gen_pkg::*;
#(
    parameter int unsigned RATIO = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic up_wrap,
    output logic wrap,
    output logic cp
);

    localparam int unsigned    CW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0]  LAST = CW'(RATIO - 1);

    if (RATIO < 1) begin : g_ratio_chk
        $error("tick_div_stage: RATIO must be >= 1");
    end

    logic [CW-1:0] cnt;

    // With RATIO=1 LAST is 0, so cnt never leaves 0 and wrap == up_wrap.
    assign wrap = up_wrap && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (up_wrap) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

`ifdef TICK_GEN_CP_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cp <= 1'b0;
        end else if (wrap) begin
            cp <= ~cp;
        end
    end
`else
    assign cp = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel tick generator (prescaler + NCH cascaded dividers).
//   clk    : system clock
//   rst    : synchronous active-high reset (clears everything incl. uptime)
//   en     : count enable; all counters hold while low, tick reads 0
//   clr    : synchronous restart of prescaler and channels; uptime kept
//   tick   : one-cycle strobe per channel, registered from the wrap vector
//   cp     : per-channel toggle clock (only with TICK_GEN_CP_EN, else 0)
//   uptime : count of tick[NCH-1] pulses, wraps modulo 2^UW
// Optional feature macro: TICK_GEN_CP_EN.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned        CLK_HZ  = CLK_HZ_DEF,
    parameter int unsigned        BASE_HZ = BASE_HZ_DEF,
    parameter int unsigned        NCH     = NCH_DEF,
    parameter int unsigned        RW      = RW_DEF,
    parameter logic [NCH*RW-1:0]  RATIOS  = RATIOS_DEF,
    parameter int unsigned        UW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] cp,
    output logic [UW-1:0]  uptime
);

    localparam int unsigned   PRE      = CLK_HZ / BASE_HZ;
    localparam int unsigned   PW       = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

    if (PRE < 2) begin : g_pre_chk
        $error("tick_gen: CLK_HZ/BASE_HZ must be >= 2");
    end

    logic [PW-1:0]  pcnt;
    logic           pwrap;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] up_wrap;

    assign pwrap = en && (pcnt == PRE_LAST);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        if (k == 0) begin : g_first
            assign up_wrap[k] = pwrap;
        end else begin : g_chain
            assign up_wrap[k] = wrap[k-1];
        end

        tick_div_stage #(
            .RATIO (32'(RATIOS[k*RW +: RW]))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .up_wrap (up_wrap[k]),
            .wrap    (wrap[k]),
            .cp      (cp[k])
        );
    end

    // clr outranks a coincident wrap: the strobe and uptime step are dropped.
    // While en is low pwrap is 0, so the whole wrap vector is 0 and tick clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt   <= '0;
            tick   <= '0;
            uptime <= '0;
        end else if (clr) begin
            pcnt   <= '0;
            tick   <= '0;
        end else begin
            tick <= wrap;
            if (en) begin
                pcnt <= pwrap ? '0 : pcnt + 1'b1;
            end
            if (wrap[NCH-1]) begin
                uptime <= uptime + 1'b1;
            end
        end
    end

endmodule
